// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shift register, LSB first, with a load handshake,
// a bit counter and a one-cycle completion pulse.
module piso_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             si,
    input  logic             shift_en,
    output logic             q,
    output logic             q_valid,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               load;
    logic               shift;
    logic [WIDTH-1:0]   sel_word;

    assign load  = (state_q == IDLE) && load_valid;
    assign shift = (state_q == SHIFT) && shift_en;

    // Per-bit 2:1 select: parallel data on load, otherwise the upper neighbour.
    for (genvar i = 0; i < WIDTH; i++) begin : g_sel
        if (i == WIDTH - 1) begin : g_msb
            assign sel_word[i] = load ? d[i] : si;
        end else begin : g_mid
            assign sel_word[i] = load ? d[i] : sr_q[i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (load || shift) begin
            sr_d = sel_word;
        end
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Leaving on the last decrement keeps cnt from underflowing.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == IDLE);
        q_valid    = (state_q == SHIFT);
        q          = sr_q[0];
        done       = done_q;
        p          = sr_q;
    end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed self-checking bench for piso_shifter (WIDTH=8).
module tb_piso_shifter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] d = '0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic             si = 1'b0;
    logic             shift_en = 1'b0;
    logic             q;
    logic             q_valid;
    logic             done;
    logic [WIDTH-1:0] p;

    int checks = 0;
    int errors = 0;

    piso_shifter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .si         (si),
        .shift_en   (shift_en),
        .q          (q),
        .q_valid    (q_valid),
        .done       (done),
        .p          (p)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; shift_en = 1'b0; si = 1'b0;
        step(); step();
        checks++; if ({q, q_valid, load_ready, done} !== 4'b0010 || p !== 8'h00) begin
            errors++; $display("FAIL reset_init: q/qv/lr/done=%b p=%h, want 0010 p=00", {q, q_valid, load_ready, done}, p);
        end
        rst = 1'b0;
        d = 8'hA5; load_valid = 1'b1; step();
        load_valid = 1'b0; shift_en = 1'b1;
        step(); step(); step();
        checks++; if (q_valid !== 1'b1 || p !== 8'h14) begin
            errors++; $display("FAIL reset_pre: qv=%b p=%h, want 1 p=14", q_valid, p);
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if ({q, q_valid, load_ready, done} !== 4'b0010 || p !== 8'h00) begin
                errors++; $display("FAIL reset_mid%0d: q/qv/lr/done=%b p=%h, want 0010 p=00", c, {q, q_valid, load_ready, done}, p);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++; if (done !== 1'b0 || q_valid !== 1'b0) begin
                errors++; $display("FAIL reset_nodone%0d: done=%b qv=%b, want 0 0", c, done, q_valid);
            end
        end
        shift_en = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_bits;
        exp_bits = 8'hA5;
        si = 1'b0; d = 8'hA5; load_valid = 1'b1;
        checks++; if (load_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready: load_ready=%b, want 1", load_ready);
        end
        step();
        load_valid = 1'b0; shift_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (q !== exp_bits[k] || q_valid !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL basic_bit%0d: q=%b qv=%b done=%b, want %b 1 0", k, q, q_valid, done, exp_bits[k]);
            end
            step();
        end
        checks++; if (done !== 1'b1 || load_ready !== 1'b1 || q_valid !== 1'b0 || p !== 8'h00) begin
            errors++; $display("FAIL basic_done: done=%b lr=%b qv=%b p=%h, want 1 1 0 00", done, load_ready, q_valid, p);
        end
        shift_en = 1'b0;
        step();
        checks++; if (done !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: done=%b, want 0", done);
        end
    endtask

    task automatic test_stalls();
        logic [10:0] pat;
        logic [7:0]  exp_bits;
        int          acc;
        pat = 11'b11111011001;   // bit j = shift_en in cycle j: 1,0,0,1,1,0,1,1,1,1,1
        exp_bits = 8'h81;
        acc = 0;
        si = 1'b0; d = 8'h81; load_valid = 1'b1; step();
        load_valid = 1'b0;
        for (int j = 0; j < 11; j++) begin
            checks++; if (q !== exp_bits[acc] || q_valid !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL stall_c%0d: q=%b qv=%b done=%b, want %b 1 0", j, q, q_valid, done, exp_bits[acc]);
            end
            shift_en = pat[j];
            step();
            if (pat[j]) acc++;
        end
        checks++; if (done !== 1'b1 || q_valid !== 1'b0) begin
            errors++; $display("FAIL stall_done: done=%b qv=%b, want 1 0", done, q_valid);
        end
        shift_en = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'hF00F;  // LSB first: 1111 0000 0000 1111
        si = 1'b0; d = 8'h0F; load_valid = 1'b1; step();
        d = 8'hF0; shift_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (q !== stream[k] || load_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_w0_%0d: q=%b lr=%b, want %b 0", k, q, load_ready, stream[k]);
            end
            step();
        end
        checks++; if (done !== 1'b1 || load_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_done0: done=%b lr=%b, want 1 1", done, load_ready);
        end
        step();
        load_valid = 1'b0;
        checks++; if (done !== 1'b0 || q_valid !== 1'b1 || p !== 8'hF0) begin
            errors++; $display("FAIL b2b_reload: done=%b qv=%b p=%h, want 0 1 f0", done, q_valid, p);
        end
        for (int k = 8; k < 16; k++) begin
            checks++; if (q !== stream[k] || done !== 1'b0) begin
                errors++; $display("FAIL b2b_w1_%0d: q=%b done=%b, want %b 0", k, q, done, stream[k]);
            end
            step();
        end
        checks++; if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_done1: done=%b, want 1", done);
        end
        shift_en = 1'b0;
        step();
    endtask

    task automatic test_fill();
        si = 1'b1; d = 8'h00; load_valid = 1'b1; step();
        load_valid = 1'b0; shift_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (q !== 1'b0 || load_ready !== 1'b0) begin
                errors++; $display("FAIL fill_bit%0d: q=%b lr=%b, want 0 0", k, q, load_ready);
            end
            if (k == 3) begin
                d = 8'h55; load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            step();
        end
        load_valid = 1'b0;
        checks++; if (done !== 1'b1 || p !== 8'hFF) begin
            errors++; $display("FAIL fill_done: done=%b p=%h, want 1 ff", done, p);
        end
        shift_en = 1'b0;
        step();
    endtask

    task automatic test_ignored_shift();
        si = 1'b0; load_valid = 1'b0; shift_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (p !== 8'hFF || q !== 1'b1 || done !== 1'b0 || q_valid !== 1'b0 || load_ready !== 1'b1) begin
                errors++; $display("FAIL idle_shift%0d: p=%h q=%b done=%b qv=%b lr=%b, want ff 1 0 0 1", c, p, q, done, q_valid, load_ready);
            end
        end
        shift_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_back_to_back();
        test_fill();
        test_ignored_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shifter.md
# piso_shifter

Parallel-in/serial-out shift register that takes the word produced by the per-bit 2:1 select stage and clocks it out one bit per accepted shift, LSB first. Each storage bit's next-state comes from a one-bit select between "load parallel data" and "take neighbour's bit", so this block is the direct consumer of the mux/selmux stage. It adds the sequential control around that select: a bit counter, a load handshake and a completion pulse. It sits between the datapath registers and any bit-serial consumer, such as the serial port or the bit-serial ALU feed.

## Interface
- WIDTH, default 8: word length in bits. Must be ≥ 2.
- clk  in  1: single clock, rising edge.
- rst  in  1: reset, synchronous and active-high.
- d  in  WIDTH: parallel load data.
- load_valid  in  1: upstream offers `d`.
- load_ready  out  1: block accepts a load this cycle.
- si  in  1: fill bit shifted into the MSB on each shift.
- shift_en  in  1: downstream accepts the current serial bit.
- q  out  1: current serial bit, equal to sr[0].
- q_valid  out  1: `q` is a live data bit.
- done  out  1: one-cycle pulse after the final bit is accepted.
- p  out  WIDTH: current register contents, for observation.

## Operation
- State `IDLE`:
  - load_ready=1, q_valid=0.
  - load_valid=1 → sr←d, cnt←WIDTH, go to `SHIFT`.
  - load_valid=0 → hold all state. shift_en is ignored.
- State `SHIFT`:
  - load_ready=0, q_valid=1.
  - load_valid is ignored; no overwrite is allowed.
  - shift_en=1 → sr←{si, sr[WIDTH-1:1]}, cnt←cnt-1.
  - shift_en=1 with cnt==1 → go to `IDLE` and set done=1 for the next cycle.
  - shift_en=0 → hold all state.
- Bit select: each bit i uses `load ? d[i] : (i==WIDTH-1 ? si : sr[i+1])`. Enable is load OR (`SHIFT` AND shift_en).
- cnt:
  - Width is clog2(WIDTH+1) bits.
  - It never underflows, because the state leaves `SHIFT` at the cnt==1 decrement.
  - cnt==0 only in `IDLE`.
- q, load_ready and q_valid are combinational from registered state. done is registered.
- Reset:
  - rst=1 at a rising edge forces state=`IDLE`, sr=0, cnt=0, done=0. It overrides load_valid and shift_en.
  - Reset during `SHIFT` aborts the word. No done pulse is produced and the remaining bits are discarded.

## Timing
- Reset values, from the first edge with rst=1: q=0, q_valid=0, load_ready=1, done=0, p=0.
- Load handshake completes on the edge where load_valid & load_ready. The first bit, d[0], appears on q in the following cycle.
- Bit k (0-based) is consumed on the k-th edge with q_valid & shift_en. Stall cycles (shift_en=0) are allowed anywhere and freeze q.
- done is high exactly one cycle, immediately after the edge that consumed bit WIDTH-1. In that cycle load_ready=1 again.
- Minimum word period is WIDTH+1 cycles: one load cycle plus WIDTH shift cycles.
- A load accepted in the same cycle as done is valid, and done still pulses only once.
- After a full word, p equals WIDTH copies of the si values shifted in, with the oldest si at bit 0.

## Test plan
- **Reset:** assert rst for 2 cycles mid-`SHIFT`.
  - Then q=0, q_valid=0, load_ready=1, done=0, p=0 with no done pulse.
- **Basic serialize (WIDTH=8):** d=0xA5, load_valid 1 cycle, shift_en held 1, si=0.
  - q reads 1,0,1,0,0,1,0,1 over 8 cycles.
  - done pulses in cycle 10.
  - p=0x00 after the word.
- **Stalls:** d=0x81, shift_en pattern 1,0,0,1,1,0,1,1,1,1,1.
  - q is frozen during the zeros.
  - Exactly 8 bits (1,0,0,0,0,0,0,1) are consumed.
  - done comes one cycle after the 8th accept.
- **Back-to-back:** load 0x0F, then hold load_valid=1 with d=0xF0.
  - 0xF0 is accepted in the done cycle.
  - The second word is not accepted earlier; load_ready=0 for the whole first word.
  - The stream is 1111 0000 0000 1111.
- **Fill and ignore:** si=1, d=0x00, full word.
  - p=0xFF after done.
  - load_valid pulsed mid-word with d=0x55 has no effect.
- **Ignored shift:** shift_en=1 in `IDLE` for 5 cycles.
  - p, cnt and q unchanged; done stays 0.
